// File: rtl/ones_pattern_generator_if.sv
// ones_pattern_generator_if: request/handshake bundle between the pattern generator and its consumer
interface ones_pattern_generator_if #(
    parameter int WIDTH = 3
);
    localparam int CW = $clog2(WIDTH + 1);
    logic          start;
    logic [CW-1:0] target;
    logic          ready;
    logic [WIDTH-1:0] word;
    logic          valid;
    logic          busy;
    logic          done;
    modport master (input start, target, ready, output word, valid, busy, done);
    modport slave  (output start, target, ready, input word, valid, busy, done);
endinterface

// File: rtl/ones_pattern_generator.sv
// ones_pattern_generator: enumerates, in ascending order, every WIDTH-bit word with a requested popcount
module ones_pattern_generator #(
    parameter int WIDTH = 3
) (
    input logic                     clk,
    input logic                     rst,
    ones_pattern_generator_if.master bus
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, SCAN, EMIT, DONE} state_t;
    state_t           state, state_nx;
    logic [WIDTH-1:0] cand, cand_nx, word_q, word_nx;
    logic [CW-1:0]    tgt, tgt_nx, ones;
    logic             match, last;
    // population count of the current candidate, sized to the target field
    always_comb begin
        ones = '0;
        for (int i = 0; i < WIDTH; i++) ones = ones + CW'(cand[i]);
    end
    assign match = ones == tgt;
    assign last  = &cand;
    // state and datapath registers; reset clears everything immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cand   <= '0;
            tgt    <= '0;
            word_q <= '0;
        end else begin
            state  <= state_nx;
            cand   <= cand_nx;
            tgt    <= tgt_nx;
            word_q <= word_nx;
        end
    end
    // next-state: scan one candidate per cycle, stop on the all-ones word so cand never wraps
    always_comb begin
        state_nx = state;
        cand_nx  = cand;
        tgt_nx   = tgt;
        word_nx  = word_q;
        case (state)
            IDLE: if (bus.start) begin
                tgt_nx   = bus.target;
                cand_nx  = '0;
                state_nx = SCAN;
            end
            SCAN: if (match) begin
                word_nx  = cand;
                state_nx = EMIT;
            end else if (last) begin
                state_nx = DONE;
            end else begin
                cand_nx  = cand + 1'b1;
            end
            EMIT: if (bus.ready) begin
                state_nx = last ? DONE : SCAN;
                cand_nx  = last ? cand : cand + 1'b1;
            end
            default: state_nx = IDLE;
        endcase
    end
    assign bus.word  = word_q;
    assign bus.valid = state == EMIT;
    assign bus.busy  = state != IDLE;
    assign bus.done  = state == DONE;
endmodule

// File: tb/tb_ones_pattern_generator.sv
// tb_ones_pattern_generator: directed checks of ordered pattern enumeration, stalls, reset and out-of-range targets
module tb_ones_pattern_generator;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;
    always #5 clk = ~clk;
    ones_pattern_generator_if #(.WIDTH(3)) b3 ();
    ones_pattern_generator_if #(.WIDTH(4)) b4 ();
    ones_pattern_generator #(.WIDTH(3)) u3 (.clk(clk), .rst(rst), .bus(b3));
    ones_pattern_generator #(.WIDTH(4)) u4 (.clk(clk), .rst(rst), .bus(b4));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // start at edge 0, then check every edge up to the return to IDLE
    task automatic run3(input logic [1:0] t, input logic [15:0] vmask, input logic [8:0] words,
                        input int done_e, input bit b2b);
        int k = 0;
        b3.start  = 1'b1;
        b3.target = t;
        for (int e = 1; e <= done_e + 1; e++) begin
            step();
            if (e == 1) b3.start = 1'b0;
            chk($sformatf("t%0d_valid@%0d", t, e), 32'(b3.valid), 32'(vmask[e]));
            if (vmask[e]) begin
                chk($sformatf("t%0d_word@%0d", t, e), 32'(b3.word), 32'(words[8-3*k -: 3]));
                k++;
            end
            chk($sformatf("t%0d_busy@%0d", t, e), 32'(b3.busy), 32'(e <= done_e));
            chk($sformatf("t%0d_done@%0d", t, e), 32'(b3.done), 32'(e == done_e));
            if (b2b && e == done_e) begin
                b3.start  = 1'b1;
                b3.target = 2'd0;
            end
        end
    endtask

    task automatic wait_valid3(input int lim);
        int n = 0;
        while (!b3.valid && n < lim) begin
            step();
            n++;
        end
        chk("valid_seen", 32'(b3.valid), 32'd1);
    endtask

    task automatic wait_done3(input int lim);
        int n = 0;
        while (!b3.done && n < lim) begin
            step();
            n++;
        end
        chk("done_seen", 32'(b3.done), 32'd1);
        step();
        chk("idle_after_done", 32'(b3.busy), 32'd0);
    endtask

    initial begin
        logic [2:0] w;
        b3.start = 1'b0; b3.target = '0; b3.ready = 1'b1;
        b4.start = 1'b0; b4.target = '0; b4.ready = 1'b1;
        #1;
        chk("rst_valid", 32'(b3.valid), 32'd0);
        chk("rst_busy", 32'(b3.busy), 32'd0);
        chk("rst_done", 32'(b3.done), 32'd0);
        chk("rst_word", 32'(b3.word), 32'd0);
        chk("rst_busy4", 32'(b4.busy), 32'd0);
        step();
        step();
        rst = 1'b0;
        step();
        chk("idle_holds", 32'(b3.busy), 32'd0);

        run3(2'd2, 16'h0520, {3'b011, 3'b101, 3'b110}, 12, 1'b0);
        run3(2'd0, 16'h0004, {3'b000, 6'b0}, 10, 1'b0);
        run3(2'd3, 16'h0200, {3'b111, 6'b0}, 10, 1'b1);
        chk("b2b_start_in_done_ignored", 32'(b3.busy), 32'd0);
        step();
        b3.start = 1'b0;
        chk("b2b_first_idle_accepted", 32'(b3.busy), 32'd1);
        step();
        chk("b2b_valid", 32'(b3.valid), 32'd1);
        chk("b2b_word", 32'(b3.word), 32'd0);
        wait_done3(20);

        b3.ready = 1'b0;
        b3.start = 1'b1;
        b3.target = 2'd1;
        step();
        b3.start = 1'b0;
        b3.target = 2'd3;
        for (int i = 0; i < 3; i++) begin
            w = 3'(1 << i);
            wait_valid3(20);
            chk($sformatf("stall_word%0d", i), 32'(b3.word), 32'(w));
            for (int s = 0; s < 3; s++) begin
                step();
                chk($sformatf("stall_valid%0d_%0d", i, s), 32'(b3.valid), 32'd1);
                chk($sformatf("stall_hold%0d_%0d", i, s), 32'(b3.word), 32'(w));
            end
            chk($sformatf("y1y0_%0d", i), 32'($countones(b3.word)), 32'd1);
            b3.ready = 1'b1;
            step();
            b3.ready = 1'b0;
            chk($sformatf("accepted%0d", i), 32'(b3.valid), 32'd0);
        end
        wait_done3(20);

        b3.start = 1'b1;
        b3.target = 2'd2;
        step();
        b3.start = 1'b0;
        wait_valid3(20);
        chk("mid_first", 32'(b3.word), 32'(3'b011));
        b3.ready = 1'b1;
        step();
        b3.ready = 1'b0;
        wait_valid3(20);
        chk("mid_second", 32'(b3.word), 32'(3'b101));
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(b3.valid), 32'd0);
        chk("mid_rst_busy", 32'(b3.busy), 32'd0);
        chk("mid_rst_done", 32'(b3.done), 32'd0);
        chk("mid_rst_word", 32'(b3.word), 32'd0);
        step();
        rst = 1'b0;
        b3.ready = 1'b1;
        step();
        run3(2'd2, 16'h0520, {3'b011, 3'b101, 3'b110}, 12, 1'b0);

        b4.start = 1'b1;
        b4.target = 3'd5;
        for (int e = 1; e <= 18; e++) begin
            step();
            b4.start = (e == 5 || e == 10);
            b4.target = 3'd1;
            chk($sformatf("w4_valid@%0d", e), 32'(b4.valid), 32'd0);
            chk($sformatf("w4_busy@%0d", e), 32'(b4.busy), 32'(e <= 17));
            chk($sformatf("w4_done@%0d", e), 32'(b4.done), 32'(e == 17));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ones_pattern_generator.md
# ones_pattern_generator

Sequential inverse of the gate-level ones counter: given a requested ones-count, enumerates, in ascending binary order, every WIDTH-bit word whose population count equals that target. Each word is presented one at a time on a valid/ready handshake. The block drives the a/b/c inputs of the ones-counter units under self-checking benches: each emitted word must produce a counter output equal to the latched target.

## Interface
- WIDTH, 3, word width; must be ≥ 2.
- CW, $clog2(WIDTH+1), width of the target/count field; derived, not overridden.
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a new enumeration; sampled only in IDLE.
- target  input  CW  requested ones-count; latched on an accepted start.
- ready  input  1  consumer accepts the current word when high with valid.
- word  output  WIDTH  current emitted pattern (word[2:0] = {a,b,c} for WIDTH=3).
- valid  output  1  word is a matching pattern and awaits acceptance.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when the enumeration is complete.

## Operation
- Registers: state, cand (WIDTH bits), tgt (CW bits), word (WIDTH bits).
- States:
  - IDLE: on start, tgt<=target, cand<=0, go to SCAN. Otherwise hold.
  - SCAN: examine cand.
    - If popcount(cand)==tgt: word<=cand and go to EMIT.
    - Else if cand==all-ones: go to DONE.
    - Else cand<=cand+1 and stay in SCAN.
  - EMIT: valid=1 and word is held stable until ready.
    - On ready with cand==all-ones: go to DONE.
    - On ready otherwise: cand<=cand+1 and go to SCAN.
    - Without ready: stay in EMIT.
  - DONE: done=1 for exactly one cycle, then go to IDLE.
- popcount is combinational over cand; the comparison is zero-extended to CW bits.
- target>WIDTH is legal. No word matches, so valid never rises and done follows a full scan.
- start outside IDLE is ignored. target changes after acceptance have no effect.
- cand never wraps: the all-ones check ends the scan before any increment past the maximum.
- Outputs are registered or decoded from state only. valid=(state==EMIT), busy=(state!=IDLE), done=(state==DONE).

## Timing
- Reset, asynchronous, takes effect immediately, including mid-enumeration:
  - state=IDLE; cand, word and tgt all 0.
  - valid=0, busy=0, done=0.
  - Release gives normal IDLE behaviour on the next edge.
- Start accepted at edge n: SCAN with cand=0 at edge n+1.
- Each non-matching candidate costs one cycle.
- A match found at SCAN edge k is presented (valid, word) after edge k+1.
- With ready held high, EMIT lasts one cycle.
- ready low stalls indefinitely; word must not change while valid=1.
- After the last candidate: DONE for one cycle, then IDLE. busy falls on the same edge done falls.
- Back-to-back: start asserted during the DONE cycle is ignored; start in the first IDLE cycle is accepted.

## Test plan
- WIDTH=3, ready=1, start with target=2 at edge 0:
  - valid after edges 5, 8, 10 with word=011, 101, 110.
  - done pulse after edge 12.
  - busy high edges 1–12.
- target=0: word=000 valid after edge 2. No further matches; done after edge 10.
- target=3: a single word=111 valid after edge 9; done after edge 10. Verify cand never wraps to 000.
- target=1, ready toggling (low 3 cycles per word):
  - words 001, 010, 100, each held stable while stalled.
  - Each word applied to the ones counter gives y1y0=01.
- Reset mid-run: assert rst while EMIT with word=101.
  - valid, busy and done drop immediately; word=000.
  - A new start with target=2 restarts from cand=0 and reproduces the first scenario.
- WIDTH=4, target=5 (out of range): valid never asserted; done after a 16-cycle scan. start pulses while busy are ignored.
